// File: rtl/inst_fetch.sv
// Fetch stage: PC, in-order imem requests, FIFO of returned words to decode. Word returned in cycle N is on dec_* in N+1.
// Requests are credit-limited to FIFO_DEPTH (outstanding + buffered); FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
module inst_fetch #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [6:0]      dec_opcode
`ifdef FETCH_MISALIGN_TRAP_EN
  ,output logic           fetch_misalign
`endif
);

  localparam int unsigned   PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned   SW   = CW + 1;
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [XLEN-1:0] instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] ipc_q   [FIFO_DEPTH];

  logic            credit_ok, req_fire, rsp_eff, push, pop, trap;
  logic [XLEN-1:0] redir_pc, push_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign trap           = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_pc       = redirect_pc;
  assign fetch_misalign = mis_q;
`else
  logic unused_redirect_lsbs;
  assign trap                 = 1'b0;
  assign redir_pc             = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign credit_ok      = (SW'(out_q) + SW'(cnt_q)) < SW'(FIFO_DEPTH);
  assign imem_req_valid = (state_q == RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding (e.g. issued before a reset) are ignored.
  assign rsp_eff        = imem_rsp_valid && (out_q != '0);
  assign push           = rsp_eff && (drop_q == '0) && !redirect_valid;
  assign dec_valid      = (cnt_q != '0);
  assign pop            = dec_valid && dec_ready && !redirect_valid;
  // Surviving in-flight requests are consecutive and end at pc_q-4, so the oldest one's PC is derived.
  assign push_pc        = pc_q - XLEN'({out_q, 2'b00});

  assign dec_instr  = dec_valid ? instr_q[rd_q] : '0;
  assign dec_pc     = dec_valid ? ipc_q[rd_q]   : '0;
  assign dec_opcode = dec_instr[6:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    out_d   = out_q + CW'(req_fire) - CW'(rsp_eff);
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      BOOT:    state_d = RUN;
      default: state_d = state_q;
    endcase
    if (redirect_valid) begin
      pc_d   = redir_pc;
      cnt_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
      drop_d = out_q - CW'(rsp_eff);
      if (trap) state_d = HALT;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (trap) mis_d = 1'b1;
`endif
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (rsp_eff && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_q] <= imem_rsp_data;
      ipc_q[wr_q]   <= push_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: per-cycle vector table plus hand sequences for misaligned redirect and mid-run reset.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc;
  logic [6:0]  dec_opcode;
  logic        misalign;
  logic        w_req_valid, w_dec_valid, w_misalign;
  logic [31:0] w_req_addr, w_dec_instr, w_dec_pc;
  logic [6:0]  w_dec_opcode;

  int total = 0;
  int bad   = 0;
  bit mem_hold = 1'b0;
  logic [31:0] mem_q [$];

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_opcode(dec_opcode)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misalign(misalign)
`endif
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(w_dec_valid), .dec_ready(dec_ready), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc),
    .dec_opcode(w_dec_opcode)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misalign(w_misalign)
`endif
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign misalign   = 1'b0;
  assign w_misalign = 1'b0;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    case (a[4:2])
      3'd0: op = 7'h33;
      3'd1: op = 7'h03;
      3'd2: op = 7'h67;
      3'd3: op = 7'h23;
      3'd4: op = 7'h13;
      3'd5: op = 7'h6F;
      3'd6: op = 7'h37;
      default: op = 7'h17;
    endcase
    return {a[24:0], op};
  endfunction

  // Memory: answers one cycle after acceptance, in order, unless held.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!mem_hold && mem_q.size() > 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      if (rst && imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
    end
  end

  typedef struct {
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          hold;
    bit          e_rq;
    logic [31:0] e_addr;
    bit          e_dv;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_row(input vec_t v, input int id);
    logic [31:0] w;
    @(negedge clk);
    dec_ready      = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    mem_hold       = v.hold;
    #2;
    w = mem_word(v.e_pc);
    chk($sformatf("r%0d req_vld", id), 32'(imem_req_valid), 32'(v.e_rq));
    if (v.e_rq) chk($sformatf("r%0d req_addr", id), imem_req_addr, v.e_addr);
    chk($sformatf("r%0d dec_vld", id), 32'(dec_valid), 32'(v.e_dv));
    if (v.e_dv) begin
      chk($sformatf("r%0d dec_pc", id), dec_pc, v.e_pc);
      chk($sformatf("r%0d dec_opcode", id), 32'(dec_opcode), 32'(w[6:0]));
      chk($sformatf("r%0d dec_instr", id), dec_instr, w);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req_vld"}, 32'(imem_req_valid), 32'd0);
    chk({tag, " req_addr"}, imem_req_addr, 32'h0);
    chk({tag, " dec_vld"}, 32'(dec_valid), 32'd0);
    chk({tag, " dec_instr"}, dec_instr, 32'h0);
    chk({tag, " dec_pc"}, dec_pc, 32'h0);
    chk({tag, " dec_opcode"}, 32'(dec_opcode), 32'd0);
    chk({tag, " misalign"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    //            rdy rv rpc            hold rq  addr           dv  pc
    tbl[0]  = '{1, 0, 32'h0,          0,   1,  32'h0,         0,  32'h0};
    tbl[1]  = '{1, 0, 32'h0,          0,   1,  32'h4,         0,  32'h0};
    tbl[2]  = '{1, 0, 32'h0,          0,   0,  32'h0,         1,  32'h0};
    tbl[3]  = '{1, 0, 32'h0,          0,   1,  32'h8,         1,  32'h4};
    tbl[4]  = '{1, 0, 32'h0,          0,   1,  32'hC,         0,  32'h0};
    tbl[5]  = '{1, 0, 32'h0,          0,   0,  32'h0,         1,  32'h8};
    tbl[6]  = '{0, 0, 32'h0,          0,   1,  32'h10,        1,  32'hC};
    tbl[7]  = '{0, 0, 32'h0,          0,   0,  32'h0,         1,  32'hC};
    tbl[8]  = '{0, 0, 32'h0,          0,   0,  32'h0,         1,  32'hC};
    tbl[9]  = '{0, 0, 32'h0,          0,   0,  32'h0,         1,  32'hC};
    tbl[10] = '{1, 0, 32'h0,          0,   0,  32'h0,         1,  32'hC};
    tbl[11] = '{1, 0, 32'h0,          0,   1,  32'h14,        1,  32'h10};
    tbl[12] = '{1, 0, 32'h0,          0,   1,  32'h18,        0,  32'h0};
    tbl[13] = '{1, 0, 32'h0,          1,   0,  32'h0,         1,  32'h14};
    tbl[14] = '{1, 0, 32'h0,          1,   1,  32'h1C,        0,  32'h0};
    tbl[15] = '{1, 1, 32'h100,        0,   0,  32'h0,         0,  32'h0};
    tbl[16] = '{1, 0, 32'h0,          0,   1,  32'h100,       0,  32'h0};
    tbl[17] = '{1, 0, 32'h0,          0,   1,  32'h104,       0,  32'h0};
    tbl[18] = '{1, 0, 32'h0,          0,   0,  32'h0,         1,  32'h100};
    tbl[19] = '{1, 1, 32'hFFFF_FFFC,  0,   0,  32'h0,         1,  32'h104};
    tbl[20] = '{1, 0, 32'h0,          0,   1,  32'hFFFF_FFFC, 0,  32'h0};
    tbl[21] = '{1, 0, 32'h0,          0,   1,  32'h0,         0,  32'h0};
    tbl[22] = '{1, 0, 32'h0,          0,   0,  32'h0,         1,  32'hFFFF_FFFC};

    rst = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (3) @(negedge clk);
    #2;
    chk_reset("reset");
    chk("wrap reset addr", w_req_addr, 32'hFFFF_FFFC);

    @(negedge clk);
    rst = 1'b1;
    dec_ready = 1'b1;
    #2;
    chk("boot req_vld", 32'(imem_req_valid), 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_row(tbl[i], i + 1);
      if (i == 0) begin
        chk("wrap first vld", 32'(w_req_valid), 32'd1);
        chk("wrap first addr", w_req_addr, 32'hFFFF_FFFC);
      end
      if (i == 1) chk("wrap second addr", w_req_addr, 32'h0);
    end

    // Misaligned redirect while decode holds a valid word.
    run_row('{1, 1, 32'h102, 0, 0, 32'h0, 1, 32'h0}, 24);
    run_row('{1, 0, 32'h0, 0, !MIS, 32'h100, 0, 32'h0}, 25);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign sticky", 32'(misalign), 32'd1);
`endif
    run_row('{1, 0, 32'h0, 0, !MIS, 32'h104, 0, 32'h0}, 26);
    run_row('{1, 0, 32'h0, 0, 0, 32'h0, !MIS, 32'h100}, 27);

    // Reset with a response still pending; it arrives during boot and must be ignored.
    run_row('{0, 0, 32'h0, 1, !MIS, 32'h108, !MIS, 32'h104}, 28);
    run_row('{0, 0, 32'h0, 1, 0, 32'h0, !MIS, 32'h104}, 29);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_reset("midreset");
    @(negedge clk);
    rst = 1'b1;
    mem_hold = 1'b0;
    dec_ready = 1'b1;
    #2;
    chk("reboot req_vld", 32'(imem_req_valid), 32'd0);
    chk("reboot dec_vld", 32'(dec_valid), 32'd0);
    run_row('{1, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0}, 30);
    run_row('{1, 0, 32'h0, 0, 1, 32'h4, 0, 32'h0}, 31);
    run_row('{1, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0}, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
